// File: rtl/mul.sv
// Registered binary16 multiplier: one result per clock, latency 1, exp=0 treated as zero.
// Optional macro MUL_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the fraction is truncated.
module mul (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] flp_a,
  input  logic [15:0] flp_b,
  output logic        sign,
  output logic [4:0]  exponent,
  output logic [4:0]  exp_unbiased,
  output logic [5:0]  exp_sum,
  output logic [9:0]  prod,
  output logic [15:0] sum
);

  logic        w_sa, w_sb, w_sign;
  logic [4:0]  w_ea, w_eb;
  logic [9:0]  w_fa, w_fb;
  logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
  logic        w_nan, w_inf, w_zero;
  logic [5:0]  w_exp_sum;
  logic [4:0]  w_exp_unb;
  logic [21:0] w_mant;
  logic        w_norm_sh;
  logic [21:0] w_norm;
  logic [9:0]  w_frac_raw;
  logic        w_round_up;
  logic [10:0] w_frac_inc;
  logic        w_carry;
  logic [9:0]  w_frac;
  logic [7:0]  w_exp_pre;
  logic [7:0]  w_exp_fin;
  logic        w_ovf, w_unf;
  logic [15:0] w_result;

  logic [15:0] r_sum;
  logic [5:0]  r_exp_sum;
  logic [4:0]  r_exp_unb;

  assign w_sa   = flp_a[15];
  assign w_sb   = flp_b[15];
  assign w_ea   = flp_a[14:10];
  assign w_eb   = flp_b[14:10];
  assign w_fa   = flp_a[9:0];
  assign w_fb   = flp_b[9:0];
  assign w_sign = w_sa ^ w_sb;

  assign w_nan_a  = (&w_ea) & (|w_fa);
  assign w_nan_b  = (&w_eb) & (|w_fb);
  assign w_inf_a  = (&w_ea) & ~(|w_fa);
  assign w_inf_b  = (&w_eb) & ~(|w_fb);
  assign w_zero_a = ~(|w_ea);
  assign w_zero_b = ~(|w_eb);
  assign w_nan    = w_nan_a | w_nan_b | (w_inf_a & w_zero_b) | (w_inf_b & w_zero_a);
  assign w_inf    = w_inf_a | w_inf_b;
  assign w_zero   = w_zero_a | w_zero_b;

  assign w_exp_sum = {1'b0, w_ea} + {1'b0, w_eb};
  assign w_exp_unb = w_ea + w_eb - 5'd15;

  assign w_mant    = 22'({1'b1, w_fa}) * 22'({1'b1, w_fb});
  // Left-align so the leading one always sits at bit 21; fraction is then bits 20:11.
  assign w_norm_sh  = w_mant[21];
  assign w_norm     = w_norm_sh ? w_mant : (w_mant << 1);
  assign w_frac_raw = 10'(w_norm >> 11);

`ifdef MUL_ROUND_NEAREST_EN
  logic w_guard, w_sticky;
  assign w_guard    = w_norm[10];
  assign w_sticky   = |w_norm[9:0];
  assign w_round_up = w_guard & (w_sticky | w_frac_raw[0]);
`else
  assign w_round_up = 1'b0;
`endif

  assign w_frac_inc = {1'b0, w_frac_raw} + {10'd0, w_round_up};
  assign w_carry    = w_frac_inc[10];
  assign w_frac     = w_carry ? 10'd0 : w_frac_inc[9:0];

  // Signed 8-bit exponent so underflow below zero stays visible.
  assign w_exp_pre = {2'b00, w_exp_sum} + {7'd0, w_norm_sh} - 8'd15;
  assign w_exp_fin = w_exp_pre + {7'd0, w_carry};
  assign w_ovf     = $signed(w_exp_fin) >= 8'sd31;
  assign w_unf     = $signed(w_exp_fin) <= 8'sd0;

  always_comb begin
    w_result = {w_sign, w_exp_fin[4:0], w_frac};
    if (w_nan)
      w_result = 16'h7E00;
    else if (w_inf)
      w_result = {w_sign, 5'h1F, 10'h000};
    else if (w_zero)
      w_result = {w_sign, 15'h0000};
    else if (w_ovf)
      w_result = {w_sign, 5'h1F, 10'h000};
    else if (w_unf)
      w_result = {w_sign, 15'h0000};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum     <= 16'h0000;
      r_exp_sum <= 6'd0;
      r_exp_unb <= 5'd0;
    end else begin
      r_sum     <= w_result;
      r_exp_sum <= w_exp_sum;
      r_exp_unb <= w_exp_unb;
    end
  end

  assign sum          = r_sum;
  assign sign         = r_sum[15];
  assign exponent     = r_sum[14:10];
  assign prod         = r_sum[9:0];
  assign exp_sum      = r_exp_sum;
  assign exp_unbiased = r_exp_unb;

endmodule

// File: tb/tb_mul.sv
// Bench for mul: directed corner vectors, randomized operands against a real-valued-style reference, and async reset.
module tb_mul;

  logic        clk;
  logic        rst;
  logic [15:0] flp_a, flp_b;
  logic        sign;
  logic [4:0]  exponent, exp_unbiased;
  logic [5:0]  exp_sum;
  logic [9:0]  prod;
  logic [15:0] sum;

  int checks = 0;
  int errors = 0;

  mul dut (
    .clk(clk), .rst(rst), .flp_a(flp_a), .flp_b(flp_b),
    .sign(sign), .exponent(exponent), .exp_unbiased(exp_unbiased),
    .exp_sum(exp_sum), .prod(prod), .sum(sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer product, locate the leading one, round, rebias; returns {exp_sum, exp_unbiased, sum}.
  function automatic logic [26:0] model(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, fa, fb, p, k, sh, q, rem, half, e;
    logic s;
    logic [15:0] r;
    bit nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [5:0] es;
    logic [4:0] eu;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    nan_a = (ea == 31) && (fa != 0); nan_b = (eb == 31) && (fb != 0);
    inf_a = (ea == 31) && (fa == 0); inf_b = (eb == 31) && (fb == 0);
    zero_a = (ea == 0);              zero_b = (eb == 0);
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a))
      r = 16'h7E00;
    else if (inf_a || inf_b)
      r = {s, 5'h1F, 10'h000};
    else if (zero_a || zero_b)
      r = {s, 15'h0000};
    else begin
      p = (1024 + fa) * (1024 + fb);
      k = 0;
      for (int i = 0; i < 22; i++)
        if (((p >> i) & 1) != 0) k = i;
      sh   = k - 10;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 1 << (sh - 1);
`ifdef MUL_ROUND_NEAREST_EN
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
`endif
      if (q == 2048) begin
        q = 1024;
        k = k + 1;
      end
      e = ea + eb - 15 + (k - 20);
      if (e >= 31)
        r = {s, 5'h1F, 10'h000};
      else if (e <= 0)
        r = {s, 15'h0000};
      else
        r = {s, e[4:0], q[9:0]};
    end
    es = 6'(ea + eb);
    eu = 5'(ea + eb - 15);
    return {es, eu, r};
  endfunction

  task automatic check_outputs(input string tag, input logic [26:0] m);
    checks++;
    assert (sum === m[15:0]) else begin
      errors++; $error("FAIL %s sum observed=%h expected=%h", tag, sum, m[15:0]);
    end
    checks++;
    assert (sign === m[15]) else begin
      errors++; $error("FAIL %s sign observed=%b expected=%b", tag, sign, m[15]);
    end
    checks++;
    assert (exponent === m[14:10]) else begin
      errors++; $error("FAIL %s exponent observed=%h expected=%h", tag, exponent, m[14:10]);
    end
    checks++;
    assert (prod === m[9:0]) else begin
      errors++; $error("FAIL %s prod observed=%h expected=%h", tag, prod, m[9:0]);
    end
    checks++;
    assert (exp_sum === m[26:21]) else begin
      errors++; $error("FAIL %s exp_sum observed=%h expected=%h", tag, exp_sum, m[26:21]);
    end
    checks++;
    assert (exp_unbiased === m[20:16]) else begin
      errors++; $error("FAIL %s exp_unbiased observed=%h expected=%h", tag, exp_unbiased, m[20:16]);
    end
    $display("op %s a=%h b=%h sum=%h exp_sum=%h exp_unb=%h", tag, flp_a, flp_b, sum, exp_sum, exp_unbiased);
  endtask

  task automatic check_zero(input string tag);
    checks++;
    assert ({sign, exponent, exp_unbiased, exp_sum, prod, sum} === 43'd0) else begin
      errors++;
      $error("FAIL %s reset outputs observed=%h_%h_%h_%h_%h_%h expected=all zero",
             tag, sign, exponent, exp_unbiased, exp_sum, prod, sum);
    end
    $display("reset %s sum=%h", tag, sum);
  endtask

  // Drive at a falling edge; result is checked at the next falling edge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input string tag);
    logic [26:0] m;
    flp_a = a;
    flp_b = b;
    m = model(a, b);
    @(negedge clk);
    check_outputs(tag, m);
  endtask

  task automatic run_directed(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] want, input string tag);
    run_op(a, b, tag);
    checks++;
    assert (sum === want) else begin
      errors++; $error("FAIL %s directed sum observed=%h expected=%h", tag, sum, want);
    end
  endtask

  function automatic logic [15:0] rand_operand();
    logic [15:0] v;
    int pick;
    v = 16'($urandom);
    pick = int'($urandom_range(0, 9));
    case (pick)
      0: v[14:10] = 5'd0;
      1: v[14:10] = 5'd31;
      2: v[14:10] = 5'(int'($urandom_range(1, 4)));
      3: v[14:10] = 5'(int'($urandom_range(26, 30)));
      4: begin v[14:10] = 5'd31; v[9:0] = 10'd0; end
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    logic [15:0] a, b;
    logic [26:0] m;
    rst   = 1'b1;
    flp_a = 16'h1234;
    flp_b = 16'h5678;
    #2;
    check_zero("power_on");
    @(negedge clk);
    flp_a = 16'hFFFF;
    flp_b = 16'h7C00;
    @(negedge clk);
    check_zero("held_in_reset");
    rst = 1'b0;

`ifdef MUL_ROUND_NEAREST_EN
    run_directed(16'hAAAA, 16'hCCCC, 16'h3BFE, "aaaa_x_cccc");
`else
    run_directed(16'hAAAA, 16'hCCCC, 16'h3BFD, "aaaa_x_cccc");
`endif
    checks++;
    assert (exp_sum === 6'b011101 && exp_unbiased === 5'b01110 && exponent === 5'b01110) else begin
      errors++;
      $error("FAIL aaaa_x_cccc exps observed=%b/%b/%b expected=011101/01110/01110",
             exp_sum, exp_unbiased, exponent);
    end
    run_directed(16'h3C00, 16'h3C00, 16'h3C00, "one_x_one");
    run_directed(16'h4000, 16'hC200, 16'hC600, "two_x_m3");
    run_directed(16'h7BFF, 16'h7BFF, 16'h7C00, "overflow");
    run_directed(16'h7C00, 16'h0000, 16'h7E00, "inf_x_zero");
    run_directed(16'hFC00, 16'h4000, 16'hFC00, "ninf_x_two");
    run_directed(16'h0400, 16'h0400, 16'h0000, "underflow");
    run_directed(16'h8001, 16'h3C00, 16'h8000, "subnormal_flush");
    run_directed(16'hFE01, 16'hBC00, 16'h7E00, "nan_operand");

    for (int i = 0; i < 300; i++) begin
      a = rand_operand();
      b = rand_operand();
      run_op(a, b, $sformatf("rand%0d", i));
    end

    // Asynchronous reset while streaming, asserted between clock edges.
    for (int j = 0; j < 3; j++) begin
      flp_a = rand_operand();
      flp_b = 16'h3C00 | 16'($urandom_range(0, 1023));
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_zero($sformatf("async_assert%0d", j));
      flp_a = 16'($urandom);
      flp_b = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      check_zero($sformatf("async_hold%0d", j));
      a = rand_operand();
      b = rand_operand();
      flp_a = a;
      flp_b = b;
      m = model(a, b);
      rst = 1'b0;
      #2 check_zero($sformatf("post_release%0d", j));
      @(negedge clk);
      check_outputs($sformatf("resume%0d", j), m);
      run_op(rand_operand(), rand_operand(), $sformatf("resume_next%0d", j));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul.md
MUL -- requirements
Module: mul

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock; the only clock.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: flp_a  input  16  IEEE-754 binary16 operand A ({sign, exp[4:0], frac[9:0]}, bias 15).
REQ-004 SHALL have port: flp_b  input  16  binary16 operand B, same format.
REQ-005 SHALL have port: sign  output  1  result sign.
REQ-006 SHALL have port: exponent  output  5  final biased result exponent, equal to sum[14:10].
REQ-007 SHALL have port: exp_unbiased  output  5  diagnostic value exp_a + exp_b - 15, low 5 bits.
REQ-008 SHALL have port: exp_sum  output  6  diagnostic raw sum exp_a + exp_b.
REQ-009 SHALL have port: prod  output  10  final result fraction, equal to sum[9:0].
REQ-010 SHALL have port: sum  output  16  packed binary16 product {sign, exponent, prod}.

Function
REQ-011 SHALL sample flp_a/flp_b on every rising clk and register all outputs: latency 1 cycle, throughput 1 result/cycle, no handshake.
REQ-012 SHALL compute sign = flp_a[15] XOR flp_b[15] for all cases except NaN.
REQ-013 SHALL compute exp_sum and exp_unbiased from raw exponent fields in every case, special cases included.
REQ-014 SHALL multiply 11-bit significands {1,frac} into a 22-bit product; if bit21=1, normalize right by 1 and add 1 to the exponent.
REQ-015 SHALL form the fraction from the 10 bits below the leading one; rounding per REQ-027/028.
REQ-016 SHALL, when a rounding increment carries out of the fraction, set the fraction to 0 and add 1 to the exponent.
REQ-017 SHALL treat exp=0 operands (zero and subnormal) as zero; no subnormal inputs or outputs.
REQ-018 SHALL output canonical qNaN sum=16'h7E00 (sign=0) if either operand is NaN (exp=31, frac!=0) or for Inf x zero.
REQ-019 SHALL output signed infinity {sign,5'h1F,10'h0} for Inf x finite-nonzero.
REQ-020 SHALL output signed zero {sign,15'h0} for a zero operand with no Inf/NaN.
REQ-021 SHALL output signed infinity on overflow: final biased exponent >= 31.
REQ-022 SHALL flush underflow (final biased exponent <= 0) to signed zero.
REQ-023 SHALL precede in this order: NaN, Inf, zero, overflow, underflow, normal.

Reset
REQ-024 SHALL clear sign, exponent, exp_unbiased, exp_sum, prod and sum to 0 immediately while rst=1, independent of clk.
REQ-025 SHALL discard the in-flight result on reset mid-operation; the first valid output is 1 cycle after the first clk edge with rst=0.
REQ-026 SHALL NOT require inputs to be stable during reset.

Configuration
REQ-027 SHALL, with macro MUL_ROUND_NEAREST_EN defined, round to nearest-even using guard plus sticky (OR of the remaining bits).
REQ-028 SHALL, without MUL_ROUND_NEAREST_EN, truncate (round toward zero); latency and all other behaviour are unchanged.

Verification
REQ-029 SHALL cover: flp_a=16'hAAAA, flp_b=16'hCCCC -> sign=0, exp_sum=6'b011101, exp_unbiased=5'b01110, exponent=5'b01110, prod=10'h3FE with sum=16'h3BFE (round en); prod=10'h3FD with sum=16'h3BFD (truncate).
REQ-030 SHALL cover: 16'h3C00 x 16'h3C00 -> sum=16'h3C00; 16'h4000 x 16'hC200 -> sum=16'hC600, sign=1.
REQ-031 SHALL cover: 16'h7BFF x 16'h7BFF -> sum=16'h7C00 (overflow to +Inf).
REQ-032 SHALL cover: 16'h7C00 x 16'h0000 -> sum=16'h7E00; 16'hFC00 x 16'h4000 -> sum=16'hFC00.
REQ-033 SHALL cover: 16'h0400 x 16'h0400 -> sum=16'h0000 (underflow flush); 16'h8001 x 16'h3C00 -> sum=16'h8000.
REQ-034 SHALL cover: assert rst between clk edges while streaming -> all outputs 0 at once; after release, results resume with 1-cycle latency.
